// File: rtl/irq_stim_pkg.sv
// irq_stim_pkg: shared channel state encoding and channel-index sizing helper
package irq_stim_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, PEND} chan_state_e;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/irq_chan.sv
// irq_chan: one interrupt channel FSM with period counter, ack and sticky overrun
module irq_chan import irq_stim_pkg::*; #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             we,
  input  logic [CNT_W-1:0] period,
  input  logic             periodic,
  input  logic             ack,
  output logic             irq,
  output logic             overrun
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  chan_state_e st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n, per, per_n;
  logic mode, mode_n, ovr_n, expire;
  assign expire = cnt == '0;
  assign irq = st == PEND;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st      <= IDLE;
      cnt     <= '0;
      per     <= '0;
      mode    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      st      <= st_n;
      cnt     <= cnt_n;
      per     <= per_n;
      mode    <= mode_n;
      overrun <= ovr_n;
    end
  // A config write always wins over a same-edge expiry or ack.
  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    per_n  = per;
    mode_n = mode;
    ovr_n  = overrun;
    if (we) begin
      per_n  = period;
      mode_n = periodic;
      ovr_n  = 1'b0;
      cnt_n  = period - ONE;
      st_n   = (period == '0 || hold) ? IDLE : COUNT;
    end else if (hold) st_n = IDLE;
    else
      case (st)
        COUNT: begin
          cnt_n = expire ? per - ONE : cnt - ONE;
          st_n  = expire ? PEND : COUNT;
        end
        PEND:
          if (mode) begin
            cnt_n = expire ? per - ONE : cnt - ONE;
            st_n  = (ack && !expire) ? COUNT : PEND;
            ovr_n = overrun | (expire & ~ack);
          end else st_n = ack ? IDLE : PEND;
        default: st_n = st;
      endcase
  end
endmodule

// File: rtl/irq_stim_gen.sv
// irq_stim_gen: CPU reset sequencer plus NCH programmable interrupt channels
module irq_stim_gen import irq_stim_pkg::*; #(
  parameter int NCH        = 4,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [ch_w(NCH)-1:0]  cfg_ch,
  input  logic [CNT_W-1:0]      cfg_period,
  input  logic                  cfg_periodic,
  input  logic [NCH-1:0]        ack,
  input  logic [NCH-1:0]        mask,
  output logic                  sys_reset,
  output logic [NCH-1:0]        irq,
  output logic [NCH-1:0]        overrun,
  output logic                  interrupt
);
  localparam int CH_W = ch_w(NCH);
  localparam int RC_W = $clog2(RST_CYCLES + 1);
  logic [RC_W-1:0] rc;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sys_reset <= 1'b1;
      rc        <= '0;
    end else if (sys_reset) begin
      rc        <= rc + RC_W'(1);
      sys_reset <= rc != RC_W'(RST_CYCLES - 1);
    end
  for (genvar g = 0; g < NCH; g++) begin : g_chan
    irq_chan #(.CNT_W(CNT_W)) u_chan (
      .clk      (clk),
      .reset    (reset),
      .hold     (sys_reset),
      .we       (cfg_we && cfg_ch == CH_W'(g)),
      .period   (cfg_period),
      .periodic (cfg_periodic),
      .ack      (ack[g]),
      .irq      (irq[g]),
      .overrun  (overrun[g])
    );
  end
  assign interrupt = |(irq & mask);
endmodule

// File: tb/tb_irq_stim_gen.sv
// tb_irq_stim_gen: table-driven directed bench for irq_stim_gen
module tb_irq_stim_gen;
  logic        clk, reset, cfg_we, cfg_periodic, sys_reset, interrupt;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_period;
  logic [3:0]  ack, mask, irq, overrun;
  int pass_n = 0;
  int total_n = 0;

  typedef struct {
    logic        we;
    logic [1:0]  ch;
    logic [15:0] per;
    logic        pdc;
    logic [3:0]  ack;
    logic [3:0]  mask;
    logic [3:0]  e_irq;
    logic [3:0]  e_ovr;
  } vec_t;
  vec_t tv[$];

  irq_stim_gen #(.NCH(4), .CNT_W(16), .RST_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_periodic(cfg_periodic), .ack(ack),
    .mask(mask), .sys_reset(sys_reset), .irq(irq), .overrun(overrun),
    .interrupt(interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total_n++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else pass_n++;
  endtask

  task automatic v(input int we, input int ch, input int per, input int pdc,
                   input int ak, input int mk, input int ei, input int eo);
    vec_t t;
    t.we = 1'(we); t.ch = 2'(ch); t.per = 16'(per); t.pdc = 1'(pdc);
    t.ack = 4'(ak); t.mask = 4'(mk); t.e_irq = 4'(ei); t.e_ovr = 4'(eo);
    tv.push_back(t);
  endtask
  task automatic w(input int ch, input int per, input int pdc, input int ei, input int eo);
    v(1, ch, per, pdc, 0, 15, ei, eo);
  endtask
  task automatic n(input int ei, input int eo);
    v(0, 0, 0, 0, 0, 15, ei, eo);
  endtask
  task automatic a(input int ak, input int ei, input int eo);
    v(0, 0, 0, 0, ak, 15, ei, eo);
  endtask
  task automatic m(input int mk, input int ei);
    v(0, 0, 0, 0, 0, mk, ei, 0);
  endtask

  task automatic idle_inputs();
    cfg_we = 1'b0; cfg_ch = 2'd0; cfg_period = 16'd0; cfg_periodic = 1'b0; ack = 4'h0;
  endtask

  initial begin
    reset = 1'b0; mask = 4'hF;
    idle_inputs();
    // one-shot ch0, period 5: rises 5 edges after the write, ack clears, never re-fires
    w(0, 5, 0, 0, 0); repeat (4) n(0, 0); n(1, 0); a(1, 0, 0); repeat (4) n(0, 0);
    // periodic ch1, period 4, acked one cycle after each rise
    w(1, 4, 1, 0, 0); repeat (3) n(0, 0); n(2, 0); a(2, 0, 0); n(0, 0); n(0, 0);
    n(2, 0); a(2, 0, 0); n(0, 0); n(0, 0); n(2, 0); a(2, 0, 0); w(1, 0, 0, 0, 0);
    // periodic ch2, period 3, never acked: overrun at +6, cleared by reconfigure
    w(2, 3, 1, 0, 0); n(0, 0); n(0, 0); n(4, 0); n(4, 0); n(4, 0); n(4, 4); n(4, 4);
    w(2, 0, 0, 0, 0);
    // ch3 rewritten on its expiry edge: no irq, fresh count
    w(3, 3, 0, 0, 0); n(0, 0); n(0, 0); w(3, 3, 0, 0, 0); n(0, 0); n(0, 0); n(8, 0);
    a(8, 0, 0); n(0, 0);
    // ch1 periodic period 2: ack coincident with expiry in PEND keeps irq, no overrun
    w(1, 2, 1, 0, 0); n(0, 0); n(2, 0); n(2, 0); a(2, 2, 0); a(2, 0, 0); n(2, 0);
    w(1, 0, 0, 0, 0);
    // masking with ch0 and ch1 pending
    w(0, 1, 0, 0, 0); w(1, 1, 0, 1, 0); m(2, 3); m(0, 3); m(1, 3); m(4, 3);

    repeat (3) tick();
    chk("reset sys_reset", 4'(sys_reset), 4'h1);
    chk("reset irq", irq, 4'h0);
    chk("reset overrun", overrun, 4'h0);
    chk("reset interrupt", 4'(interrupt), 4'h0);
    reset = 1'b1;
    tick();
    chk("seq edge1 sys_reset", 4'(sys_reset), 4'h1);
    chk("seq edge1 irq", irq, 4'h0);
    tick();
    chk("seq edge2 sys_reset", 4'(sys_reset), 4'h0);
    chk("seq edge2 irq", irq, 4'h0);

    foreach (tv[i]) begin
      cfg_we = tv[i].we; cfg_ch = tv[i].ch; cfg_period = tv[i].per;
      cfg_periodic = tv[i].pdc; ack = tv[i].ack; mask = tv[i].mask;
      tick();
      chk($sformatf("v%0d irq", i), irq, tv[i].e_irq);
      chk($sformatf("v%0d overrun", i), overrun, tv[i].e_ovr);
      chk($sformatf("v%0d interrupt", i), 4'(interrupt), 4'(|(tv[i].e_irq & tv[i].mask)));
    end
    idle_inputs();
    mask = 4'hF;

    // ch2 periodic period 1 overruns two edges after the write, then mid-run reset
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_period = 16'd1; cfg_periodic = 1'b1;
    tick();
    idle_inputs();
    tick();
    tick();
    chk("pre-reset irq", irq, 4'h7);
    chk("pre-reset overrun", overrun, 4'h4);
    chk("pre-reset interrupt", 4'(interrupt), 4'h1);
    #2 reset = 1'b0;
    #1;
    chk("async reset irq", irq, 4'h0);
    chk("async reset overrun", overrun, 4'h0);
    chk("async reset interrupt", 4'(interrupt), 4'h0);
    chk("async reset sys_reset", 4'(sys_reset), 4'h1);
    tick();
    tick();
    chk("held reset sys_reset", 4'(sys_reset), 4'h1);
    reset = 1'b1;
    tick();
    chk("reseq edge1 sys_reset", 4'(sys_reset), 4'h1);
    tick();
    chk("reseq edge2 sys_reset", 4'(sys_reset), 4'h0);
    repeat (12) tick();
    chk("post-reset irq", irq, 4'h0);
    chk("post-reset overrun", overrun, 4'h0);
    chk("post-reset interrupt", 4'(interrupt), 4'h0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/irq_stim_gen.md
# irq_stim_gen

Parametrised, synthesisable stimulus source for the pipelined MIPS core with interrupt support. It sequences the CPU's active-high reset and drives `NCH` independently programmable interrupt channels, each one-shot or periodic. Each channel has a per-channel acknowledge and sticky overrun detection. It sits between the bench/board top and `mips`: `sys_reset` feeds the CPU reset, and `interrupt` feeds the CPU interrupt input. It replaces hand-coded `#delay` stimulus with cycle-exact, reusable behaviour.

## Interface
- `NCH`, 4: number of interrupt channels (1..16).
- `CNT_W`, 16: width of per-channel period counter.
- `RST_CYCLES`, 2: cycles `sys_reset` stays high after `reset` deasserts (≥1).
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cfg_we` in 1: write strobe for one channel's configuration.
- `cfg_ch` in $clog2(NCH): channel selected by `cfg_we`.
- `cfg_period` in CNT_W: expiry period in cycles; 0 disables the channel.
- `cfg_periodic` in 1: 1 = reload after expiry, 0 = one-shot.
- `ack` in NCH: per-channel acknowledge, one-cycle pulse.
- `mask` in NCH: per-channel enable into the `interrupt` summary.
- `sys_reset` out 1: active-high reset to the CPU.
- `irq` out NCH: per-channel pending level.
- `overrun` out NCH: sticky; a periodic expiry occurred while already pending.
- `interrupt` out 1: `|(irq & mask)`, combinational from registers.

## Operation
- Reset (`reset`=0) has these values:
  - `sys_reset`=1.
  - `irq`, `overrun` = 0.
  - All channels are IDLE with period 0 and periodic 0.
  - `interrupt`=0.
- Reset sequencer:
  - On `reset` rising, count `RST_CYCLES` clocks, then drop `sys_reset` to 0.
  - While `sys_reset`=1, channel FSMs hold IDLE, but configuration writes are accepted.
- Per-channel FSM has three states: IDLE, COUNT, PEND.
  - A config write to ch loads period/mode. If period≠0, go to COUNT with cnt = period−1. If period=0, go to IDLE and clear `irq`.
  - COUNT: decrement cnt each cycle. At cnt=0, go to PEND and set `irq`=1. If periodic, reload cnt = period−1.
  - PEND: `irq`=1.
    - Periodic channels keep counting; if cnt reaches 0 again while in PEND, set `overrun`=1, reload, and stay in PEND.
    - `ack` moves periodic channels to COUNT, with the counter continuing unaltered.
    - `ack` moves one-shot channels to IDLE.
    - `irq` clears on the cycle after `ack`.
  - `ack` in IDLE or COUNT is ignored.
- `overrun` clears only on reset or on a config write to that channel.
- Arithmetic is unsigned, modulo CNT_W. There is no wrap beyond the reload.

## Timing
- Config write at edge N: `irq` rises at edge N+period.
- Periodic channel: expiries fall exactly `period` cycles apart, independent of ack latency.
- `ack` sampled at edge N: `irq`=0 after edge N.
- `interrupt` follows `irq`/`mask` with zero cycles of additional latency.
- Simultaneous events:
  - Config write and expiry on the same channel and edge: the config write wins; no `irq` and no `overrun`.
  - `ack` and expiry on the same edge in PEND (periodic): the ack is honoured, then the new expiry re-enters PEND, so `irq` stays 1. `overrun` is not set.
  - `ack` and expiry in COUNT: go to PEND; the ack is ignored.
- Mid-operation reset: all state clears asynchronously, and the reset sequencer restarts.

## Structure
- Shared package `irq_stim_pkg` holds the FSM state encoding `IDLE`/`COUNT`/`PEND` and the constants `CH_W=$clog2(NCH)`.
- Natural sub-module: `irq_chan`, one channel FSM plus counter, instantiated NCH times with a generate loop.
- The reset sequencer and summary OR live in the top.

## Test plan
- Reset sequencing: hold `reset`=0 for 3 cycles, then release with RST_CYCLES=2 → `sys_reset`=1 for exactly 2 more edges, then 0. All `irq`=0 throughout.
- One-shot: ch0 with period 5 and periodic 0 → `irq[0]` rises 5 cycles after the write. `ack[0]` clears it next cycle, and it never re-fires.
- Periodic with prompt ack: ch1 with period 4, acked 1 cycle after each rise → rises at +4, +8, +12; `overrun[1]` stays 0.
- Periodic without ack: ch2 with period 3, never acked → `irq[2]` rises at +3 and `overrun[2]` rises at +6. Reconfiguring ch2 clears `overrun[2]`.
- Collision: write ch3 on the same edge that its counter hits 0 → `irq[3]` stays 0 and a fresh count starts. Separately, for a periodic channel in PEND, `ack` coincident with expiry → `irq` stays 1 and `overrun`=0.
- Masking and mid-run reset: ch0 and ch1 pending, `mask`=4'b0010 → `interrupt`=1. Then `mask`=0 gives `interrupt`=0. Asserting `reset` mid-count drives all outputs to their reset values immediately.
